// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - two-stage pipelined shift/rotate unit (SLL, SRA, ROR, ROL) with zero flag and tag
module shift_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // Low amount bits are applied in stage 1, high bits in stage 2.
  localparam int LO   = AMT_W / 2;
  localparam int HI_W = AMT_W - LO;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // One shifter slice. ROL never reaches here: it is rewritten as ROR by
  // the negated amount before stage 1, so both stages only rotate right.
  // SRA stays correct across the split because an arithmetic right shift
  // keeps the sign bit in the MSB for the second stage to replicate.
  function automatic logic [WIDTH-1:0] shift_f(
    input logic [WIDTH-1:0] d,
    input logic [AMT_W-1:0] n,
    input logic [1:0]       m
  );
    logic [2*WIDTH-1:0] dbl;
    dbl = {d, d} >> n;
    case (m)
      MODE_SLL: shift_f = d << n;
      MODE_SRA: shift_f = $signed(d) >>> n;
      default:  shift_f = dbl[WIDTH-1:0];
    endcase
  endfunction

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [HI_W-1:0]  s1_amt_hi_q, s1_amt_hi_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  // Stage 2 (output) registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_zero_q, out_zero_d;
  logic [TAG_W-1:0] out_tag_q,  out_tag_d;

  logic             s1_ready;
  logic             s2_ready;
  logic             accept;
  logic             s2_load;
  logic [AMT_W-1:0] amt_eff;
  logic [1:0]       mode_eff;
  logic [WIDTH-1:0] s2_result;

  // Backward-flowing ready chain: a stage can take new data when empty or when it drains this cycle.
  always_comb begin
    s2_ready = !s2_valid_q || out_ready;
    s1_ready = !s1_valid_q || s2_ready;
    in_ready = s1_ready && !flush;
    accept   = in_valid && in_ready;
    s2_load  = s2_ready && s1_valid_q;
  end

  // Stage 1 next state: fold ROL into ROR, apply the low amount bits, carry the rest forward.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_amt_hi_d = s1_amt_hi_q;
    s1_mode_d   = s1_mode_q;
    s1_tag_d    = s1_tag_q;
    amt_eff     = (in_mode == MODE_ROL) ? -in_amt : in_amt;
    mode_eff    = (in_mode == MODE_ROL) ? MODE_ROR : in_mode;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_ready) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_data_d   = shift_f(in_data, {{HI_W{1'b0}}, amt_eff[LO-1:0]}, mode_eff);
      s1_amt_hi_d = amt_eff[AMT_W-1:LO];
      s1_mode_d   = mode_eff;
      s1_tag_d    = in_tag;
    end
  end

  // Stage 2 next state: apply the high amount bits and form the zero flag; hold while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_zero_d = out_zero_q;
    out_tag_d  = out_tag_q;
    s2_result  = shift_f(s1_data_q, {s1_amt_hi_q, {LO{1'b0}}}, s1_mode_q);
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_ready) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      out_data_d = s2_result;
      out_zero_d = (s2_result == '0);
      out_tag_d  = s1_tag_q;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_amt_hi_q <= '0;
      s1_mode_q   <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_amt_hi_q <= s1_amt_hi_d;
      s1_mode_q   <= s1_mode_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_tag   = out_tag_q;

endmodule
